// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared definitions for the instruction-ROM read-port arbiter.
//   ID_M0 / ID_M1 : requester identifiers carried in the response tags
//   LATENCY_MAX   : deepest ROM read latency the tag pipeline supports
//   tag_t         : one tag pipeline stage {valid, id, err}
package rom_arb_pkg;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  localparam int LATENCY_MAX = 4;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   clk   : system clock
//   reset : asynchronous, active-high reset; forces grants low while high
//   req   : request vector, bit 0 = m0, bit 1 = m1
//   gnt   : combinational one-hot grant vector
// The `last` register remembers which requester was granted most recently;
// on contention the other requester wins. It resets to m1 so m0 wins the
// first contention after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req[0] && req[1]) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // The pointer only moves on a real grant, so withdrawn requests and idle
  // cycles leave the fairness order untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous instruction-ROM read port between the
// fetch requester (m0) and the debug/display requester (m1).
//   clk, reset             : clock, asynchronous active-high reset
//   mX_req / mX_addr       : read request and byte address, held until mX_gnt
//   mX_gnt                 : request accepted this cycle
//   mX_rvalid / mX_rdata   : read response for requester X, LATENCY cycles after gnt
//   mX_err                 : response address was misaligned or out of range
//   rom_addr / rom_q       : ROM word address out, ROM data in
//   busy                   : a read is granted this cycle or still in flight
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ROM_AW  = 5,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  generate
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("rom_arbiter: LATENCY must be within 1..%0d", LATENCY_MAX);
    end
  endgenerate

  logic [1:0] gnt;
  tag_t       new_tag;
  tag_t       stages [LATENCY];
  tag_t       tag_out;

  // An address is flagged when it is not word aligned or when any bit above
  // the ROM word index is set; the read itself still goes out truncated.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ROM_AW + 2)) != '0);
  endfunction

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Steer the granted address to the ROM and build the tag that will travel
  // alongside the read; with no grant the ROM sees word 0 and an empty tag.
  always_comb begin
    rom_addr = '0;
    new_tag  = '0;
    if (gnt[0]) begin
      rom_addr      = m0_addr[ROM_AW+1:2];
      new_tag.valid = 1'b1;
      new_tag.id    = ID_M0;
      new_tag.err   = addr_err(m0_addr);
    end else if (gnt[1]) begin
      rom_addr      = m1_addr[ROM_AW+1:2];
      new_tag.valid = 1'b1;
      new_tag.id    = ID_M1;
      new_tag.err   = addr_err(m1_addr);
    end
  end

  // The tag pipeline is as deep as the ROM latency, so the last stage always
  // describes the word currently on rom_q. Reset empties it, which drops any
  // reads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= new_tag;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[LATENCY-1];

  // Response steering: both requesters see rom_q and qualify it with their
  // own rvalid.
  assign m0_rvalid = tag_out.valid && (tag_out.id == ID_M0);
  assign m1_rvalid = tag_out.valid && (tag_out.id == ID_M1);
  assign m0_err    = tag_out.err;
  assign m1_err    = tag_out.err;
  assign m0_rdata  = rom_q;
  assign m1_rdata  = rom_q;

  always_comb begin
    busy = |gnt;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | stages[i].valid;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: drives two arbiters (ROM latency 1 and 2) with identical
// request streams and compares them against a cycle-indexed reference model
// of grants and responses built from the arbitration rules.
module tb_rom_arbiter;

  localparam int ADDR_W = 16;
  localparam int ROM_AW = 5;
  localparam int DATA_W = 32;
  localparam int MAXC   = 512;

  logic              clk;
  logic              reset;
  logic              m0_req;
  logic              m1_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;

  logic              m0_gnt_a    [2];
  logic              m0_rvalid_a [2];
  logic              m0_err_a    [2];
  logic [DATA_W-1:0] m0_rdata_a  [2];
  logic              m1_gnt_a    [2];
  logic              m1_rvalid_a [2];
  logic              m1_err_a    [2];
  logic [DATA_W-1:0] m1_rdata_a  [2];
  logic [ROM_AW-1:0] rom_addr_a  [2];
  logic [DATA_W-1:0] rom_q_a     [2];
  logic              busy_a      [2];

  logic [DATA_W-1:0] rom_mem [32];
  logic [ROM_AW-1:0] ap1;
  logic [ROM_AW-1:0] ap2a;
  logic [ROM_AW-1:0] ap2b;

  int checks;
  int errors;
  int cyc;
  int last_winner;
  bit eg0;
  bit eg1;
  bit rec_valid [MAXC];
  bit rec_id    [MAXC];
  bit rec_err   [MAXC];
  int rec_word  [MAXC];

  rom_arbiter #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .DATA_W(DATA_W), .LATENCY(1)) dut_lat1 (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt_a[0]),
    .m0_rvalid (m0_rvalid_a[0]),
    .m0_rdata  (m0_rdata_a[0]),
    .m0_err    (m0_err_a[0]),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt_a[0]),
    .m1_rvalid (m1_rvalid_a[0]),
    .m1_rdata  (m1_rdata_a[0]),
    .m1_err    (m1_err_a[0]),
    .rom_addr  (rom_addr_a[0]),
    .rom_q     (rom_q_a[0]),
    .busy      (busy_a[0])
  );

  rom_arbiter #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .DATA_W(DATA_W), .LATENCY(2)) dut_lat2 (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt_a[1]),
    .m0_rvalid (m0_rvalid_a[1]),
    .m0_rdata  (m0_rdata_a[1]),
    .m0_err    (m0_err_a[1]),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt_a[1]),
    .m1_rvalid (m1_rvalid_a[1]),
    .m1_rdata  (m1_rdata_a[1]),
    .m1_err    (m1_err_a[1]),
    .rom_addr  (rom_addr_a[1]),
    .rom_q     (rom_q_a[1]),
    .busy      (busy_a[1])
  );

  // Synchronous ROM models: one and two register stages from address to q.
  always @(posedge clk) begin
    ap1  <= rom_addr_a[0];
    ap2a <= rom_addr_a[1];
    ap2b <= ap2a;
  end

  assign rom_q_a[0] = rom_mem[ap1];
  assign rom_q_a[1] = rom_mem[ap2b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int word_of(input logic [ADDR_W-1:0] a);
    return (int'(a) / 4) % 32;
  endfunction

  function automatic bit err_of(input logic [ADDR_W-1:0] a);
    return (int'(a) % 4 != 0) || (int'(a) >= 4 * 32);
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return ADDR_W'($urandom_range(0, 127));
    if (sel == 1) return ADDR_W'($urandom_range(128, 65535));
    return ADDR_W'(4 * $urandom_range(0, 31));
  endfunction

  task automatic chk(input string name, input int lat, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL L%0d %s observed=0x%0h expected=0x%0h", lat, name, obs, exp);
    end
  endtask

  // Compare one arbiter instance against the model for the current cycle.
  task automatic checkOutput(input int k, input int lat);
    int j;
    bit ev0, ev1, eerr, ebusy;
    logic [DATA_W-1:0] edata;
    logic [ROM_AW-1:0] eaddr;
    j = cyc - lat;
    ev0 = 0; ev1 = 0; eerr = 0; edata = '0;
    if (j >= 0 && rec_valid[j]) begin
      ev0   = (rec_id[j] == 1'b0);
      ev1   = (rec_id[j] == 1'b1);
      eerr  = rec_err[j];
      edata = rom_mem[rec_word[j]];
    end
    ebusy = eg0 | eg1;
    for (int i = 1; i <= lat; i++) begin
      if (cyc - i >= 0 && rec_valid[cyc - i]) ebusy = 1;
    end
    eaddr = eg0 ? ROM_AW'(word_of(m0_addr)) : (eg1 ? ROM_AW'(word_of(m1_addr)) : '0);
    chk("m0_gnt", lat, 32'(m0_gnt_a[k]), 32'(eg0));
    chk("m1_gnt", lat, 32'(m1_gnt_a[k]), 32'(eg1));
    chk("rom_addr", lat, 32'(rom_addr_a[k]), 32'(eaddr));
    chk("busy", lat, 32'(busy_a[k]), 32'(ebusy));
    chk("m0_rvalid", lat, 32'(m0_rvalid_a[k]), 32'(ev0));
    chk("m1_rvalid", lat, 32'(m1_rvalid_a[k]), 32'(ev1));
    if (ev0) begin
      chk("m0_rdata", lat, m0_rdata_a[k], edata);
      chk("m0_err", lat, 32'(m0_err_a[k]), 32'(eerr));
    end
    if (ev1) begin
      chk("m1_rdata", lat, m1_rdata_a[k], edata);
      chk("m1_err", lat, 32'(m1_err_a[k]), 32'(eerr));
    end
    if (reset) begin
      chk("m0_err_reset", lat, 32'(m0_err_a[k]), 32'd0);
      chk("m1_err_reset", lat, 32'(m1_err_a[k]), 32'd0);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, then record the
  // model's grant for the coming rising edge.
  task automatic applyStimulus(input bit r, input bit r0, input logic [ADDR_W-1:0] a0,
                               input bit r1, input logic [ADDR_W-1:0] a1);
    logic [ADDR_W-1:0] ga;
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    reset = r; m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    #1;
    if (r) begin
      for (int j = 0; j < MAXC; j++) rec_valid[j] = 0;
      last_winner = 1;
    end
    eg0 = 0; eg1 = 0;
    if (!r) begin
      if (r0 && r1) begin
        if (last_winner == 1) eg0 = 1; else eg1 = 1;
      end else begin
        eg0 = r0; eg1 = r1;
      end
    end
    checkOutput(0, 1);
    checkOutput(1, 2);
    ga = eg0 ? a0 : a1;
    rec_valid[cyc] = eg0 | eg1;
    rec_id[cyc]    = eg1;
    rec_err[cyc]   = err_of(ga);
    rec_word[cyc]  = word_of(ga);
    if (eg0) last_winner = 0;
    else if (eg1) last_winner = 1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit r0, r1;
    logic [ADDR_W-1:0] a0, a1;
    checks = 0; errors = 0; cyc = 0; last_winner = 1;
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    for (int j = 0; j < MAXC; j++) rec_valid[j] = 0;
    reset = 1; m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0;
    @(negedge clk);

    // Reset state, including grants forced low while reset is held.
    applyStimulus(1, 0, 16'h0, 0, 16'h0);
    applyStimulus(1, 1, 16'h4, 1, 16'h8);

    // m0 alone, back-to-back reads of words 0..2.
    applyStimulus(0, 1, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 16'h4, 0, 16'h0);
    applyStimulus(0, 1, 16'h8, 0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    // Continuous contention from reset: m0, m1, m0, m1, ...
    applyStimulus(1, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 16'h10, 1, 16'h24);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    // m1 misaligned then out-of-range reads.
    applyStimulus(0, 0, 16'h0, 1, 16'h0006);
    applyStimulus(0, 0, 16'h0, 1, 16'h0080);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    // Reset asserted with one read in flight, then first contention.
    applyStimulus(0, 1, 16'h0C, 0, 16'h0);
    applyStimulus(1, 1, 16'h10, 1, 16'h14);
    applyStimulus(1, 1, 16'h10, 1, 16'h14);
    applyStimulus(0, 1, 16'h10, 1, 16'h14);
    applyStimulus(0, 0, 16'h0, 1, 16'h14);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    // m0 withdraws while m1 holds the bus.
    applyStimulus(0, 1, 16'h20, 1, 16'h30);
    applyStimulus(0, 1, 16'h28, 1, 16'h30);
    applyStimulus(0, 0, 16'h0, 1, 16'h38);
    applyStimulus(0, 1, 16'h2C, 1, 16'h3C);
    applyStimulus(0, 1, 16'h2C, 1, 16'h3C);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    // Randomized traffic obeying the hold-until-grant rule.
    r0 = 0; r1 = 0; a0 = '0; a1 = '0;
    for (int n = 0; n < 150; n++) begin
      if (r0 && !eg0) begin
        if ($urandom_range(0, 5) == 0) r0 = 0;
      end else begin
        r0 = ($urandom_range(0, 3) != 0);
        a0 = rand_addr();
      end
      if (r1 && !eg1) begin
        if ($urandom_range(0, 5) == 0) r1 = 0;
      end else begin
        r1 = ($urandom_range(0, 3) != 0);
        a1 = rand_addr();
      end
      applyStimulus(n == 75, r0, a0, r1, a1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
